// File: rtl/ibex_ahb_arbiter.sv
// Arbitrates the Ibex instruction-fetch and LSU request ports onto one AHB-Lite master,
// with a single outstanding single-beat transfer (IDLE -> ADDR -> DATA).
`timescale 1ns / 1ps

module ibex_ahb_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  // Instruction fetch port
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  // LSU port
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  // AHB-Lite master
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      r_state, w_next_state;
  logic        r_last_data;   // 1 = data port owned the bus last
  logic        r_owner_data;  // owner of the transfer in flight
  logic [31:0] r_haddr, r_wdata, r_hwdata, r_rdata;
  logic [2:0]  r_hsize;
  logic        r_hwrite, r_err, r_instr_rvalid, r_data_rvalid;

  logic        w_gnt_instr, w_gnt_data, w_prefer_data;
  logic [2:0]  w_data_size;
  logic [1:0]  w_data_off;
  logic        w_unused_addr_bits;

  assign w_unused_addr_bits = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  // Byte enables carry both transfer size and the byte offset inside the word.
  always_comb begin
    w_data_size = 3'b010;
    w_data_off  = 2'b00;
    case (data_be_i)
      4'b0001: begin w_data_size = 3'b000; w_data_off = 2'd0; end
      4'b0010: begin w_data_size = 3'b000; w_data_off = 2'd1; end
      4'b0100: begin w_data_size = 3'b000; w_data_off = 2'd2; end
      4'b1000: begin w_data_size = 3'b000; w_data_off = 2'd3; end
      4'b0011: begin w_data_size = 3'b001; w_data_off = 2'd0; end
      4'b1100: begin w_data_size = 3'b001; w_data_off = 2'd2; end
      default: begin w_data_size = 3'b010; w_data_off = 2'd0; end
    endcase
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_gnt_instr   = 1'b0;
    w_gnt_data    = 1'b0;
    w_prefer_data = !FAIR || !r_last_data;
    w_next_state  = r_state;
    case (r_state)
      IDLE: begin
        if (!HRESET) begin
          if (data_req_i && instr_req_i) begin
            w_gnt_data  = w_prefer_data;
            w_gnt_instr = !w_prefer_data;
          end else begin
            w_gnt_data  = data_req_i;
            w_gnt_instr = instr_req_i;
          end
        end
        if (w_gnt_data || w_gnt_instr) w_next_state = ADDR;
      end
      ADDR:    if (HREADY) w_next_state = DATA;
      DATA:    if (HREADY) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state        <= IDLE;
      r_last_data    <= 1'b0;
      r_owner_data   <= 1'b0;
      r_haddr        <= '0;
      r_hsize        <= '0;
      r_hwrite       <= 1'b0;
      r_wdata        <= '0;
      r_hwdata       <= '0;
      r_rdata        <= '0;
      r_err          <= 1'b0;
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      if (w_gnt_data) begin
        r_last_data  <= 1'b1;
        r_owner_data <= 1'b1;
        r_haddr      <= {data_addr_i[31:2], w_data_off};
        r_hsize      <= w_data_size;
        r_hwrite     <= data_we_i;
        r_wdata      <= data_wdata_i;
      end else if (w_gnt_instr) begin
        r_last_data  <= 1'b0;
        r_owner_data <= 1'b0;
        r_haddr      <= {instr_addr_i[31:2], 2'b00};
        r_hsize      <= 3'b010;
        r_hwrite     <= 1'b0;
      end
      if (r_state == ADDR && HREADY) r_hwdata <= r_wdata;
      if (r_state == DATA && HREADY) begin
        r_rdata        <= HRDATA;
        r_err          <= HRESP;
        r_data_rvalid  <= r_owner_data;
        r_instr_rvalid <= !r_owner_data;
      end
    end
  end

  assign HTRANS = (r_state == ADDR) ? 2'b10 : 2'b00;
  assign HBURST = 3'b000;
  assign HADDR  = r_haddr;
  assign HSIZE  = r_hsize;
  assign HWRITE = r_hwrite;
  assign HWDATA = r_hwdata;

  assign instr_gnt_o    = w_gnt_instr;
  assign data_gnt_o     = w_gnt_data;
  assign instr_rvalid_o = r_instr_rvalid;
  assign data_rvalid_o  = r_data_rvalid;
  assign instr_rdata_o  = r_rdata;
  assign data_rdata_o   = r_rdata;
  assign instr_err_o    = r_err;
  assign data_err_o     = r_err;

endmodule

// File: doc/ibex_ahb_arbiter.md
IBEX_AHB_ARBITER -- requirements
Module: ibex_ahb_arbiter

Interface
REQ-001 Parameter SHALL be: FAIR, 1, 1 = round-robin between data and instruction ports; 0 = fixed data priority.
REQ-002 The block SHALL use one clock, HCLK, and the reset HRESET, which is synchronous and active-high.
REQ-003 HCLK  in  1  system clock.
REQ-004 HRESET  in  1  synchronous active-high reset.
REQ-005 instr_req_i  in  1 / instr_addr_i  in  32  fetch request and address.
REQ-006 instr_gnt_o  out  1 / instr_rvalid_o  out  1 / instr_rdata_o  out  32 / instr_err_o  out  1  fetch grant, response valid, read data, bus error.
REQ-007 data_req_i  in  1 / data_we_i  in  1 / data_be_i  in  4 / data_addr_i  in  32 / data_wdata_i  in  32  LSU request, write-enable, byte enables, address, write data.
REQ-008 data_gnt_o  out  1 / data_rvalid_o  out  1 / data_rdata_o  out  32 / data_err_o  out  1  LSU grant, response valid, read data, bus error.
REQ-009 HADDR  out  32 / HTRANS  out  2 / HSIZE  out  3 / HBURST  out  3 / HWRITE  out  1 / HWDATA  out  32  AHB-Lite master outputs.
REQ-010 HRDATA  in  32 / HREADY  in  1 / HRESP  in  1  AHB-Lite read data, transfer done, error.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ADDR (address phase) and DATA (data phase).
REQ-012 In IDLE with at least one request, the block SHALL assert exactly one gnt (combinational, same cycle) to the winner, register its address, control and write data, and move to ADDR.
REQ-013 Arbitration on simultaneous requests: with FAIR=1 the port not granted last SHALL win; with FAIR=0 data SHALL always win.
REQ-014 The last-owner register SHALL update on every grant.
REQ-015 No gnt SHALL be asserted in ADDR or DATA, so only one transfer is ever outstanding.
REQ-016 In ADDR, outputs SHALL be: HTRANS=2'b10 (NONSEQ), HBURST=3'b000 (SINGLE), HADDR, HSIZE and HWRITE from the registered request.
REQ-017 The block SHALL leave ADDR for DATA on HREADY=1, and SHALL stay in ADDR with outputs held stable while HREADY=0.
REQ-018 In IDLE and DATA, HTRANS SHALL be 2'b00.
REQ-019 HADDR, HSIZE and HWRITE SHALL hold their last values outside ADDR.
REQ-020 HWDATA SHALL carry the registered write data throughout DATA and hold its value otherwise.
REQ-021 In DATA, on HREADY=1 the block SHALL register HRDATA and HRESP and return to IDLE; on the next cycle it SHALL pulse the owner's rvalid for one cycle, with rdata and err equal to the registered values.
REQ-022 Minimum latency SHALL be: gnt at cycle 0, address phase at cycle 1, data phase at cycle 2, rvalid at cycle 3.
REQ-023 A new grant SHALL be possible in the same cycle as rvalid.
REQ-024 Instruction transfers SHALL use HWRITE=0, HSIZE=3'b010, and HADDR={addr[31:2],2'b00}.
REQ-025 Data transfer size and address SHALL be decoded from data_be_i:
- 4'b0001, 4'b0010, 4'b0100, 4'b1000: HSIZE=3'b000, HADDR[1:0]=0, 1, 2, 3 respectively.
- 4'b0011, 4'b1100: HSIZE=3'b001, HADDR[1:0]=0, 2 respectively.
- Any other pattern: HSIZE=3'b010, HADDR[1:0]=0.
- In all cases, HADDR[31:2]=data_addr_i[31:2].
REQ-026 HRESP SHALL be sampled only when HREADY=1.
REQ-027 An error response (first cycle HREADY=0/HRESP=1, second cycle HREADY=1/HRESP=1) SHALL complete the transfer with err=1; no retry SHALL be made.
REQ-028 rdata SHALL be returned for writes as well and is don't-care to the requester.
REQ-029 A request deasserted before it is granted SHALL be dropped without any bus activity.

Reset
REQ-030 While HRESET=1, on each HCLK edge:
- state SHALL become IDLE and last-owner SHALL become instruction;
- HTRANS, HSIZE, HBURST, HWRITE, HADDR and HWDATA SHALL become 0;
- all gnt, rvalid, rdata and err outputs SHALL become 0.
REQ-031 Reset asserted in ADDR or DATA SHALL abort the transfer: HTRANS=2'b00 on the next cycle, no rvalid issued for the aborted transfer, and no gnt while HRESET=1.

Verification
REQ-032 Fetch instr_addr_i=0x0000_0082 with HREADY=1 and HRDATA=0x0000_0013 -> instr_gnt_o at cycle 0; at cycle 1 HTRANS=10, HADDR=0x0000_0080, HSIZE=010, HWRITE=0; at cycle 3 instr_rvalid_o=1, instr_rdata_o=0x0000_0013, instr_err_o=0.
REQ-033 Byte store with be=4'b0100, addr=0x2000_0004, wdata=0x00AB_0000 -> HADDR=0x2000_0006, HSIZE=000, HWRITE=1 in ADDR; HWDATA=0x00AB_0000 in DATA; data_rvalid_o one cycle after completion.
REQ-034 With FAIR=1, both requests held high for four transfers -> grant order data, instr, data, instr.
REQ-035 With FAIR=0, the same stimulus -> data wins all four transfers.
REQ-036 HREADY=0 for 2 cycles in DATA -> rvalid delayed exactly 2 cycles, HTRANS=00 throughout, and no gnt while pending.
REQ-037 Error response (HREADY=0/HRESP=1, then HREADY=1/HRESP=1) on a data load -> data_rvalid_o=1 with data_err_o=1; the next request proceeds normally.
REQ-038 HRESET pulsed in ADDR -> HTRANS=00 next cycle, no rvalid ever for the aborted transfer, and the first request after reset is granted.
